// File: rtl/clk_div_bank_if.sv
// Divider-bank control/status bundle: run enables, phase sync, divisor writes,
// and per-channel tick/square/pending outputs.
interface clk_div_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int DIV_W  = 32
);
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] cfg_pending;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  modport master (output en, sync, cfg_we, cfg_ch, cfg_div,
                  input  cfg_pending, tick, sq);
  modport slave  (input  en, sync, cfg_we, cfg_ch, cfg_div,
                  output cfg_pending, tick, sq);
endinterface

// File: rtl/clk_div_bank.sv
// Multi-channel clock-enable generator: per-channel programmable divisor, tick strobe,
// 50% square wave, glitch-free divisor swap at wrap, global phase sync.
module clk_div_ch #(
  parameter int               DIV_W   = 32,
  parameter logic [DIV_W-1:0] DEF_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             pend_o,
  output logic             tick_o,
  output logic             sq_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
  logic             pend_q, pend_d, tick_q, tick_d, sq_q, sq_d;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    shd_d  = wr_i ? wr_div_i : shd_q;
    if (sync_i || !en_i) begin
      // Forward a same-cycle write so the restarted channel uses the newest divisor
      cnt_d  = '0;
      sq_d   = 1'b0;
      pend_d = 1'b0;
      act_d  = wr_i ? wr_div_i : shd_q;
    end else if (act_q == '0) begin
      cnt_d = '0;
      sq_d  = 1'b0;
      if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
      if (wr_i) pend_d = 1'b1;
    end else if (cnt_q == act_q - DIV_W'(1)) begin
      // Wrap loads the shadow as it stood before this edge; a coincident write waits
      cnt_d  = '0;
      tick_d = 1'b1;
      sq_d   = ~sq_q;
      if (pend_q) begin
        act_d  = shd_q;
        pend_d = 1'b0;
      end
      if (wr_i) pend_d = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
      if (wr_i) pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= DEF_DIV;
      shd_q  <= DEF_DIV;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign pend_o = pend_q;
  assign tick_o = tick_q;
  assign sq_o   = sq_q;
endmodule

module clk_div_bank #(
  parameter int          NUM_CH  = 4,
  parameter int          CH_W    = 2,
  parameter int          DIV_W   = 32,
  parameter int unsigned DEF_DIV = 50000000
) (
  input logic           clk,
  input logic           rst_n,
  clk_div_bank_if.slave bus
);
  logic [NUM_CH-1:0] pend_w, tick_w, sq_w;

  // Out-of-range channel selects match no lane and are dropped
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(.DIV_W(DIV_W), .DEF_DIV(DIV_W'(DEF_DIV))) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (bus.en[i]),
      .sync_i   (bus.sync),
      .wr_i     (bus.cfg_we && (bus.cfg_ch == CH_W'(i))),
      .wr_div_i (bus.cfg_div),
      .pend_o   (pend_w[i]),
      .tick_o   (tick_w[i]),
      .sq_o     (sq_w[i])
    );
  end

  assign bus.cfg_pending = pend_w;
  assign bus.tick        = tick_w;
  assign bus.sq          = sq_w;
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with DEF_DIV=4; edge numbers in the
// sequence are counted from the first edge that sees the new enable.
module tb_clk_div_bank;
  localparam int NUM_CH = 4, CH_W = 2, DIV_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0, n_pass = 0;

  clk_div_bank_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_W(DIV_W)) bif ();

  clk_div_bank #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_W(DIV_W), .DEF_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] d);
    bif.cfg_we  = 1'b1;
    bif.cfg_ch  = ch;
    bif.cfg_div = d;
  endtask

  initial begin
    rst_n = 1'b0;
    bif.en = '0; bif.sync = 1'b0; bif.cfg_we = 1'b0; bif.cfg_ch = '0; bif.cfg_div = '0;
    #2;
    chk("rst_tick", 32'(bif.tick), 0);
    chk("rst_sq",   32'(bif.sq), 0);
    chk("rst_pend", 32'(bif.cfg_pending), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: default divisor 4 on ch0
    bif.en = 4'b0001;
    step(3); chk("t1_e3_tick", 32'(bif.tick), 0);
    step();  chk("t1_e4_tick", 32'(bif.tick), 4'b0001);
             chk("t1_e4_sq",   32'(bif.sq),   4'b0001);
    step(3); chk("t1_e7_sq",   32'(bif.sq),   4'b0001);
    step();  chk("t1_e8_tick", 32'(bif.tick), 4'b0001);
             chk("t1_e8_sq",   32'(bif.sq),   4'b0000);
    step(4); chk("t1_e12_tick", 32'(bif.tick), 4'b0001);

    // 2: write 6 mid-period, loads at the next wrap
    bif.en = '0; step(); bif.en = 4'b0001;
    step(5); wr(0, 6);
    step();  bif.cfg_we = 1'b0;
    chk("t2_e6_pend", 32'(bif.cfg_pending), 4'b0001);
    chk("t2_e6_tick", 32'(bif.tick), 0);
    step(2); chk("t2_e8_tick", 32'(bif.tick), 4'b0001);
             chk("t2_e8_pend", 32'(bif.cfg_pending), 0);
    step(5); chk("t2_e13_tick", 32'(bif.tick), 0);
    step();  chk("t2_e14_tick", 32'(bif.tick), 4'b0001);
             chk("t2_e14_sq",   32'(bif.sq),   4'b0001);
    step(6); chk("t2_e20_tick", 32'(bif.tick), 4'b0001);

    // 3: write on the exact wrap edge of ch1
    bif.en = '0; step(); bif.en = 4'b0010;
    step(3); wr(1, 2);
    step();  bif.cfg_we = 1'b0;
    chk("t3_e4_tick", 32'(bif.tick), 4'b0010);
    chk("t3_e4_pend", 32'(bif.cfg_pending), 4'b0010);
    step(3); chk("t3_e7_tick", 32'(bif.tick), 0);
    step();  chk("t3_e8_tick", 32'(bif.tick), 4'b0010);
             chk("t3_e8_pend", 32'(bif.cfg_pending), 0);
    step();  chk("t3_e9_tick", 32'(bif.tick), 0);
    step();  chk("t3_e10_tick", 32'(bif.tick), 4'b0010);
    step(2); chk("t3_e12_tick", 32'(bif.tick), 4'b0010);

    // 4: sync realigns div3 / div5
    bif.en = '0; wr(0, 3); step(); wr(1, 5); step(); bif.cfg_we = 1'b0; step();
    bif.en = 4'b0011;
    step(7); bif.sync = 1'b1;
    step();  bif.sync = 1'b0;
    chk("t4_s_tick", 32'(bif.tick), 0);
    chk("t4_s_sq",   32'(bif.sq),   0);
    step(3); chk("t4_s3_tick", 32'(bif.tick), 4'b0001);
             chk("t4_s3_sq",   32'(bif.sq),   4'b0001);
    step(2); chk("t4_s5_tick", 32'(bif.tick), 4'b0010);
    step();  chk("t4_s6_tick", 32'(bif.tick), 4'b0001);

    // 5: div 1, then 0 (idle), then 2 from idle
    bif.en = '0; wr(2, 1); step(); bif.cfg_we = 1'b0; step();
    bif.en = 4'b0100;
    step(); chk("t5_d1_tick_a", 32'(bif.tick), 4'b0100);
            chk("t5_d1_sq_a",   32'(bif.sq),   4'b0100);
    step(); chk("t5_d1_tick_b", 32'(bif.tick), 4'b0100);
            chk("t5_d1_sq_b",   32'(bif.sq),   0);
    step(); chk("t5_d1_sq_c",   32'(bif.sq),   4'b0100);
    wr(2, 0);
    step(); bif.cfg_we = 1'b0;
    chk("t5_d0_pend", 32'(bif.cfg_pending), 4'b0100);
    step(); chk("t5_d0_load", 32'(bif.cfg_pending), 0);
    step(); chk("t5_idle_tick", 32'(bif.tick), 0);
            chk("t5_idle_sq",   32'(bif.sq),   0);
    step(); chk("t5_idle_tick2", 32'(bif.tick), 0);
    wr(2, 2);
    step(); bif.cfg_we = 1'b0;
    chk("t5_d2_pend", 32'(bif.cfg_pending), 4'b0100);
    step(); chk("t5_d2_load", 32'(bif.cfg_pending), 0);
    step(); chk("t5_d2_m2_tick", 32'(bif.tick), 0);
    step(); chk("t5_d2_m3_tick", 32'(bif.tick), 4'b0100);
            chk("t5_d2_m3_sq",   32'(bif.sq),   4'b0100);
    step(2); chk("t5_d2_m5_tick", 32'(bif.tick), 4'b0100);
             chk("t5_d2_m5_sq",   32'(bif.sq),   0);

    // 6: async reset with a pending write
    wr(2, 7);
    step(); bif.cfg_we = 1'b0;
    chk("t6_pend_before", 32'(bif.cfg_pending), 4'b0100);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_pend", 32'(bif.cfg_pending), 0);
    chk("t6_rst_tick", 32'(bif.tick), 0);
    chk("t6_rst_sq",   32'(bif.sq),   0);
    #10 rst_n = 1'b1;
    step(3); chk("t6_e3_tick", 32'(bif.tick), 0);
             chk("t6_e3_pend", 32'(bif.cfg_pending), 0);
    step();  chk("t6_e4_tick", 32'(bif.tick), 4'b0100);
             chk("t6_e4_sq",   32'(bif.sq),   4'b0100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
